// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM generator: FSM state encoding,
// default 100 MHz timing constants and a constant-foldable clog2 helper.
package servo_pkg;

    typedef enum logic [1:0] {
        S_HIGH = 2'd0,
        S_LOW  = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    localparam int PERIOD_CYCLES_DEF = 2000000;  // 20 ms frame at 100 MHz
    localparam int PULSE_MIN_DEF     = 100000;   // 1 ms high time at position 0
    localparam int STEP_CYCLES_DEF   = 390;
    localparam int POS_W_DEF         = 8;

    // Smallest r with 2**r >= value.
    function automatic int clog2(input longint value);
        int     r;
        longint v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// PWM frame counter: pcnt runs 0..PERIOD_CYCLES-1 and wraps; frame_end
// flags the last cycle of the frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int CNT_W         = clog2(PERIOD_CYCLES + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [CNT_W-1:0] pcnt,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    assign frame_end = (pcnt == PCNT_LAST);

    // Wrap counter, restarts a fresh frame on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcnt <= '0;
        end else if (frame_end) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator for one axis. Latches step requests from the sweep
// counters, steps the position once per frame at the frame end, and drives
// the servo pulse plus end-stop flags back to the sweep counters.
// Build option SERVO_CENTER_RST_EN: reset to mid-travel instead of position 0.
//
// state  | meaning
// S_HIGH | pulse phase, PWM high until pcnt == thr-1
// S_LOW  | remainder of the frame, PWM low
// S_UPD  | last frame cycle, apply at most one position step
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int PULSE_MIN     = PULSE_MIN_DEF,
    parameter int STEP_CYCLES   = STEP_CYCLES_DEF,
    parameter int POS_W         = POS_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CNT_L,
    input  logic             CNT_R,
    output logic             PWM,
    output logic             PWM_limit,
    output logic             LIM_L,
    output logic             LIM_R,
    output logic [POS_W-1:0] POS
);

    localparam int TW = clog2(PERIOD_CYCLES + 1);
    localparam logic [POS_W-1:0] POS_MAX = '1;
`ifdef SERVO_CENTER_RST_EN
    localparam logic [POS_W-1:0] POS_RST = POS_W'(1 << (POS_W - 1));
`else
    localparam logic [POS_W-1:0] POS_RST = '0;
`endif
    localparam logic [TW-1:0] THR_RST  = TW'(PULSE_MIN + int'(POS_RST) * STEP_CYCLES);
    localparam logic [TW-1:0] STEP_T   = TW'(STEP_CYCLES);
    localparam logic [TW-1:0] PCNT_PRE = TW'(PERIOD_CYCLES - 2);
    localparam longint THR_MAX = longint'(PULSE_MIN)
                               + ((longint'(1) << POS_W) - 1) * longint'(STEP_CYCLES);

    // The widest pulse must still leave room for the low phase and S_UPD.
    generate
        if (PULSE_MIN < 1 || PERIOD_CYCLES < 3 || THR_MAX >= longint'(PERIOD_CYCLES)) begin : g_bad_cfg
            $error("servo_pwm_gen: pulse range does not fit inside the frame");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    pcnt;
    logic             frame_end;
    logic [TW-1:0]    thr;
    logic [TW-1:0]    thr_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             req_l;
    logic             req_r;
    logic             upd;
    logic             eff_l;
    logic             eff_r;
    logic             pwm_d;

    servo_frame_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .CNT_W         (TW)
    ) u_frame_timer (
        .CLK       (CLK),
        .RST       (RST),
        .pcnt      (pcnt),
        .frame_end (frame_end)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_HIGH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; S_HIGH can skip S_LOW when the pulse fills the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HIGH: begin
                if (pcnt == PCNT_PRE) begin
                    state_nxt = S_UPD;
                end else if (pcnt == thr - TW'(1)) begin
                    state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (pcnt == PCNT_PRE) begin
                    state_nxt = S_UPD;
                end
            end
            S_UPD:   state_nxt = S_HIGH;
            default: state_nxt = S_HIGH;
        endcase
    end

    // FSM output; registered below so the pulse starts one cycle after pcnt 0.
    always_comb begin
        pwm_d = (state == S_HIGH);
    end

    // Step decision; requests arriving in the update cycle itself still count.
    always_comb begin
        upd     = (state == S_UPD) && frame_end;
        eff_l   = req_l | CNT_L;
        eff_r   = req_r | CNT_R;
        pos_nxt = POS;
        thr_nxt = thr;
        if (upd && eff_l && !eff_r && POS != '0) begin
            pos_nxt = POS - POS_W'(1);
            thr_nxt = thr - STEP_T;
        end else if (upd && eff_r && !eff_l && POS != POS_MAX) begin
            pos_nxt = POS + POS_W'(1);
            thr_nxt = thr + STEP_T;
        end
    end

    // Position, threshold, request latches and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PWM       <= 1'b0;
            POS       <= POS_RST;
            thr       <= THR_RST;
            req_l     <= 1'b0;
            req_r     <= 1'b0;
            LIM_L     <= (POS_RST == '0);
            LIM_R     <= (POS_RST == POS_MAX);
            PWM_limit <= (POS_RST == '0) || (POS_RST == POS_MAX);
        end else begin
            PWM       <= pwm_d;
            POS       <= pos_nxt;
            thr       <= thr_nxt;
            req_l     <= (state == S_UPD) ? 1'b0 : (req_l | CNT_L);
            req_r     <= (state == S_UPD) ? 1'b0 : (req_r | CNT_R);
            LIM_L     <= (pos_nxt == '0);
            LIM_R     <= (pos_nxt == POS_MAX);
            PWM_limit <= (pos_nxt == '0) || (pos_nxt == POS_MAX);
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen with a 100-cycle frame. Each frame's expected
// pulse width and position go into a scoreboard when the frame's stimulus
// starts; a monitor pops them at every PWM falling edge.
module tb_servo_pwm_gen;

    localparam int PERIOD = 100;
    localparam int PMIN   = 10;
    localparam int STEP   = 2;
    localparam int PW     = 4;
    localparam int PMAX   = 15;
`ifdef SERVO_CENTER_RST_EN
    localparam int RST_POS = 8;
`else
    localparam int RST_POS = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CNT_L = 1'b0;
    logic          CNT_R = 1'b0;
    logic          PWM;
    logic          PWM_limit;
    logic          LIM_L;
    logic          LIM_R;
    logic [PW-1:0] POS;

    always #5 CLK = ~CLK;

    servo_pwm_gen #(
        .PERIOD_CYCLES (PERIOD),
        .PULSE_MIN     (PMIN),
        .STEP_CYCLES   (STEP),
        .POS_W         (PW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CNT_L     (CNT_L),
        .CNT_R     (CNT_R),
        .PWM       (PWM),
        .PWM_limit (PWM_limit),
        .LIM_L     (LIM_L),
        .LIM_R     (LIM_R),
        .POS       (POS)
    );

    typedef struct {
        int width;
        int pos;
    } frame_exp_t;

    frame_exp_t sb_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int model_pos;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // One full frame of stimulus starting at the negedge where pcnt == 0.
    task automatic do_frame(input bit l, input bit r, input bit hold);
        frame_exp_t e;
        e.width = PMIN + model_pos * STEP;
        e.pos   = model_pos;
        sb_q.push_back(e);
        for (int c = 0; c < PERIOD; c++) begin
            CNT_L = hold ? l : (l && c == 50);
            CNT_R = hold ? r : (r && c == 50);
            @(negedge CLK);
        end
        CNT_L = 1'b0;
        CNT_R = 1'b0;
        if (l && !r && model_pos != 0) model_pos--;
        else if (r && !l && model_pos != PMAX) model_pos++;
    endtask

    // Pulse monitor: width per frame from the scoreboard, period between rises.
    int hi_cnt;
    int since_rise;
    bit prev_pwm;
    initial begin
        frame_exp_t e;
        hi_cnt = 0;
        since_rise = -1;
        prev_pwm = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                hi_cnt = 0;
                since_rise = -1;
                prev_pwm = 1'b0;
            end else begin
                if (PWM && !prev_pwm) begin
                    if (since_rise >= 0) chk("period", since_rise, PERIOD);
                    since_rise = 0;
                end
                if (since_rise >= 0) since_rise++;
                if (PWM) begin
                    hi_cnt++;
                end else if (prev_pwm) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pulse", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("width", hi_cnt, e.width);
                        chk("pos", int'(POS), e.pos);
                        chk("lim_l", int'(LIM_L), int'(e.pos == 0));
                        chk("lim_r", int'(LIM_R), int'(e.pos == PMAX));
                        chk("pwm_limit", int'(PWM_limit), int'(e.pos == 0 || e.pos == PMAX));
                    end
                    hi_cnt = 0;
                end
                prev_pwm = PWM;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_pwm"}, int'(PWM), 0);
        chk({tag, "_pos"}, int'(POS), RST_POS);
        chk({tag, "_lim_l"}, int'(LIM_L), int'(RST_POS == 0));
        chk({tag, "_lim_r"}, int'(LIM_R), 0);
        chk({tag, "_pwm_limit"}, int'(PWM_limit), int'(RST_POS == 0));
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_reset_state("rst");
        RST = 1'b0;
        model_pos = RST_POS;

        repeat (3) do_frame(1'b0, 1'b0, 1'b0);
        repeat (3) do_frame(1'b0, 1'b1, 1'b0);
        do_frame(1'b0, 1'b0, 1'b0);
        repeat (20) do_frame(1'b0, 1'b1, 1'b1);
        do_frame(1'b0, 1'b0, 1'b0);
        do_frame(1'b1, 1'b1, 1'b0);
        do_frame(1'b0, 1'b0, 1'b0);
        repeat (8) do_frame(1'b1, 1'b0, 1'b0);

        // Reset in the middle of a pulse at pcnt == 5.
        repeat (5) @(negedge CLK);
        chk("pre_rst_pwm", int'(PWM), 1);
        chk("pre_rst_pos", int'(POS), 7);
        RST = 1'b1;
        #1;
        check_reset_state("midrst");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        model_pos = RST_POS;

        do_frame(1'b0, 1'b0, 1'b0);
        do_frame(1'b1, 1'b0, 1'b0);
        do_frame(1'b0, 1'b0, 1'b0);

        chk("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
